instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Assembles instruction fields (mnemonic, Rdest, Rsrc, immediate) into 16-bit instruction words for our 16-bit ISA. Writes them sequentially into instruction memory through a simple write port. It is the producing end of the instruction-word format that the decoder consumes, and it is used by the program loader and self-test sequencer. Illegal mnemonics and out-of-range immediates are rejected with a sticky error.

Parameters:
ADDR_W, 8, instruction-memory address width; last address = 2^ADDR_W-1
PAD_ALIGN, 4, alignment in words for end-of-program padding (power of 2; used only with ENCODER_NOP_PAD_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a program at base_addr
base_addr  input  ADDR_W  first write address, latched on start
in_valid  input  1  field bundle valid
in_ready  output  1  encoder accepts a bundle this cycle
in_mnemonic  input  5  mnemonic code (see Behaviour)
in_rdest  input  4  destination register
in_rsrc  input  4  source register (R-type only)
in_imm  input  16  immediate, two's complement (I-type only)
in_last  input  1  marks final bundle of the program
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  16  encoded instruction word
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at program end (normal or error)
err_code  output  2  0 none, 1 illegal mnemonic, 2 immediate out of range, 3 address overflow; sticky until next start
word_count  output  ADDR_W+1  words written since last start

Behaviour:
- Reset: state IDLE. All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_code, word_count.
- Mnemonics 0-15 are R-type, with ext = mnemonic: WAIT0 AND1 OR2 XOR3 NOT4 ADD5 ADDU6 ADDC7 RSH8 SUB9 SUBC10 CMP11 LSH12 MOV13 MUL14 ARSH15.
  - Word = {4'b0000, rdest, ext, rsrc}. in_imm is ignored.
- Mnemonics 16+k, k=5..15, are I-type with op = k: ADDI ADDUI ADDCI RSHI SUBI SUBCI CMPI LSHI MOVI MULI ARSHI.
  - Word = {op, rdest, imm8}.
  - Mnemonics 16-20 are illegal (err 1).
- Immediate range rules; a violation gives err 2:
  - ADDI, ADDCI, SUBI, SUBCI, CMPI, MULI: signed -128..127, imm8 = in_imm[7:0].
  - ADDUI, MOVI: 0..255.
  - LSHI, RSHI, ARSHI: 0..15, imm8 = {4'b0, in_imm[3:0]}.
- IDLE:
  - in_ready = 0.
  - start: latch base_addr into address counter, clear word_count and err_code, go RUN.
- RUN, accept and write:
  - in_ready = 1.
  - Handshake: a bundle is accepted when in_valid && in_ready.
  - Encoding is combinational; result is registered.
  - mem_we = 1 with mem_addr/mem_wdata exactly one cycle after acceptance.
  - Throughput: 1 word/cycle.
  - After each write: address +1, word_count +1.
- RUN, program end:
  - Accepted bundle with in_last: write it, then go IDLE; done pulses in the same cycle as that last mem_we.
- RUN, errors:
  - Illegal or out-of-range bundle: not written; err_code set; go ERR.
  - Write to address 2^ADDR_W-1 succeeds; the address is then marked exhausted.
  - A further accepted bundle (not written) gives err 3 and goes ERR; there is no wrap-around.
- ERR:
  - in_ready = 0.
  - done pulses on entry cycle + 1, then IDLE; err_code is held.
- start while busy is ignored.
- Asynchronous reset mid-program aborts immediately; no partial write completes.
- mem_wdata holds its last value when mem_we = 0.

Optional Feature:
ENCODER_NOP_PAD_EN:
- Defined: after the in_last word, if the next address is not a multiple of PAD_ALIGN:
  - state PAD writes WAIT (16'h0000) words, one per cycle, until aligned, with in_ready = 0.
  - done pulses with the final pad write.
  - Pad words count in word_count.
  - Reaching the top address during PAD stops padding without error.
- Undefined: no PAD state; done pulses with the in_last write.

Test Plan:
- start base 0x10; ADD(5) rd3 rs4, last -> one cycle later mem_we=1, addr 0x10, wdata 0x0354; done same cycle; word_count 1.
- Back-to-back ADDI(21) rd2 imm -1, MOVI(29) rd1 imm 200, LSHI(28) rd5 imm 3 (last) -> consecutive writes:
  - 0x52FF @0x10
  - 0xD1C8 @0x11
  - 0xC503 @0x12 with done
- ADDI imm 200 -> no write; err_code 2; done pulse; in_ready 0.
- Mnemonic 17 -> err_code 1, no write.
- ADDR_W=2, base 3; two bundles -> first written @3; second gives err_code 3; no write to address 0.
- Reset asserted mid-stream -> all outputs 0 asynchronously; next start works normally.
- With ENCODER_NOP_PAD_EN, PAD_ALIGN 4, base 0: 1 bundle (last) -> 0x0000 written @1, @2, @3; done with @3 write; word_count 4.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs mnemonic/register/immediate fields into 16-bit ISA words
// and streams them into instruction memory, one word per cycle.
// Optional macro ENCODER_NOP_PAD_EN: pads the program end with WAIT words up to
// a PAD_ALIGN boundary.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int PAD_ALIGN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnemonic,
  input  logic [3:0]        in_rdest,
  input  logic [3:0]        in_rsrc,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {IDLE, RUN, ERR, PAD} state_t;

  if ((PAD_ALIGN & (PAD_ALIGN - 1)) != 0) begin : g_bad_align
    $error("PAD_ALIGN must be a power of 2");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              exhausted;   // top address already written; no wrap allowed
  logic [15:0]       word;
  logic              bad_mn, bad_imm;
  logic [3:0]        op;
  logic              accept, top;
  logic [ADDR_W-1:0] nxt_addr;

  assign op       = in_mnemonic[3:0];
  assign accept   = in_valid && in_ready;
  assign top      = (addr == {ADDR_W{1'b1}});
  assign nxt_addr = addr + 1'b1;

`ifdef ENCODER_NOP_PAD_EN
  localparam logic [ADDR_W-1:0] PAD_MASK = ADDR_W'(PAD_ALIGN - 1);
  logic need_pad;
  // more padding needed only if there is room and the next address is unaligned
  assign need_pad = !top && ((nxt_addr & PAD_MASK) != '0);
`endif

  // Field encoding and legality check; R-type ext equals the mnemonic,
  // I-type op is the low nibble of the mnemonic (16+k -> k).
  always_comb begin
    word    = '0;
    bad_mn  = 1'b0;
    bad_imm = 1'b0;
    if (!in_mnemonic[4]) begin
      word = {4'b0000, in_rdest, op, in_rsrc};
    end else if (op < 4'd5) begin
      bad_mn = 1'b1;
    end else begin
      case (op)
        4'd6, 4'd13: begin                // ADDUI, MOVI: unsigned 0..255
          bad_imm = (in_imm[15:8] != '0);
          word    = {op, in_rdest, in_imm[7:0]};
        end
        4'd8, 4'd12, 4'd15: begin         // shifts: 0..15
          bad_imm = (in_imm[15:4] != '0);
          word    = {op, in_rdest, 4'b0000, in_imm[3:0]};
        end
        default: begin                    // signed -128..127: bits 15:7 all equal
          bad_imm = !((&in_imm[15:7]) || !(|in_imm[15:7]));
          word    = {op, in_rdest, in_imm[7:0]};
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (accept) begin
          if (bad_mn || bad_imm || exhausted) state_nxt = ERR;
`ifdef ENCODER_NOP_PAD_EN
          else if (in_last) state_nxt = need_pad ? PAD : IDLE;
`else
          else if (in_last) state_nxt = IDLE;
`endif
        end
      end
      ERR: state_nxt = IDLE;
`ifdef ENCODER_NOP_PAD_EN
      PAD: if (!need_pad) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state == RUN);
    busy     = (state != IDLE);
  end

  // Datapath: address/count tracking, registered write port, done and error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      exhausted  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err_code   <= 2'd0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr       <= base_addr;
          exhausted  <= 1'b0;
          err_code   <= 2'd0;
          word_count <= '0;
        end
        RUN: if (accept) begin
          if (bad_mn)         err_code <= 2'd1;
          else if (bad_imm)   err_code <= 2'd2;
          else if (exhausted) err_code <= 2'd3;
          else begin
            mem_we     <= 1'b1;
            mem_addr   <= addr;
            mem_wdata  <= word;
            word_count <= word_count + 1'b1;
            if (top) exhausted <= 1'b1;
            else     addr      <= nxt_addr;
`ifdef ENCODER_NOP_PAD_EN
            if (in_last) done <= !need_pad;
`else
            if (in_last) done <= 1'b1;
`endif
          end
        end
        ERR: done <= 1'b1;
`ifdef ENCODER_NOP_PAD_EN
        PAD: begin
          mem_we     <= 1'b1;
          mem_addr   <= addr;
          mem_wdata  <= 16'h0000;
          word_count <= word_count + 1'b1;
          if (top) exhausted <= 1'b1;
          else     addr      <= nxt_addr;
          done <= !need_pad;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes, a
// negedge monitor pops and compares each mem_we cycle.
module tb_instr_encoder;
  localparam int AW    = 8;
  localparam int ALIGN = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          done;
    logic [AW:0]   wc;
  } exp_t;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0, in_last = 1'b0;
  logic [4:0]    in_mnemonic = '0;
  logic [3:0]    in_rdest = '0, in_rsrc = '0;
  logic [15:0]   in_imm = '0;
  logic          in_ready, mem_we, busy, done;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;

  int errors = 0, checks = 0;
  exp_t q[$];
  logic [AW-1:0] m_addr;
  logic [AW:0]   m_wc;

  instr_encoder #(.ADDR_W(AW), .PAD_ALIGN(ALIGN)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnemonic(in_mnemonic),
    .in_rdest(in_rdest), .in_rsrc(in_rsrc), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: every write must match the head of the scoreboard
  exp_t e;
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h expected=no write", mem_addr, mem_wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(e.data));
        chk("wr_done", 32'(done), 32'(e.done));
        chk("wr_count", 32'(word_count), 32'(e.wc));
      end
    end
  end

  // expected-write model, including end-of-program padding when enabled
  task automatic push_write(input logic [15:0] d, input bit last);
    exp_t x;
    bit more;
    x.addr = m_addr; x.data = d; x.wc = m_wc + 1'b1; x.done = last;
    more = 0;
`ifdef ENCODER_NOP_PAD_EN
    more = last && (m_addr != '1) && (((int'(m_addr) + 1) % ALIGN) != 0);
    if (more) x.done = 1'b0;
`endif
    q.push_back(x);
    m_wc++;
    m_addr++;
    while (more) begin
      x.addr = m_addr; x.data = 16'h0000; x.wc = m_wc + 1'b1;
      more   = (m_addr != '1) && (((int'(m_addr) + 1) % ALIGN) != 0);
      x.done = !more;
      q.push_back(x);
      m_wc++;
      m_addr++;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    @(negedge clk); start = 1'b1; base_addr = b;
    m_addr = b; m_wc = '0;
    @(negedge clk); start = 1'b0;
  endtask

  // present one bundle, wait for acceptance; ok=1 means a write is expected
  task automatic send(input logic [4:0] mn, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [15:0] imm, input bit last, input logic [15:0] w, input bit ok);
    int n;
    @(negedge clk);
    in_mnemonic = mn; in_rdest = rd; in_rsrc = rs; in_imm = imm; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    else begin
      @(posedge clk);
      if (ok) push_write(w, last);
    end
  endtask

  task automatic idle();
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] exp_err);
    int n;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("done_seen", 32'(done), 32'd1);
    chk("err_code", 32'(err_code), 32'(exp_err));
    repeat (2) @(negedge clk);
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err_code"}, 32'(err_code), 0);
    chk({tag, "_word_count"}, 32'(word_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_addr = '0; m_wc = '0;
    #12 check_zero("reset");
    @(negedge clk); reset = 1'b0;

    // single R-type word
    do_start(8'h10);
    send(5'd5, 4'd3, 4'd4, 16'h0, 1, 16'h0354, 1);
    idle();
    wait_done(2'd0);
    chk("wc_single", 32'(word_count), 32'(m_wc));

    // back-to-back I-type words
    do_start(8'h10);
    send(5'd21, 4'd2, 4'd0, 16'hFFFF, 0, 16'h52FF, 1);
    send(5'd29, 4'd1, 4'd0, 16'd200,  0, 16'hD1C8, 1);
    send(5'd28, 4'd5, 4'd0, 16'd3,    1, 16'hC503, 1);
    idle();
    wait_done(2'd0);

    // range edges: SUBI -128, ARSHI 15, MOV R-type
    do_start(8'h40);
    send(5'd25, 4'd0, 4'd0, 16'hFF80, 0, 16'h9080, 1);
    send(5'd31, 4'd7, 4'd0, 16'd15,   0, 16'hF70F, 1);
    send(5'd13, 4'd1, 4'd2, 16'hBEEF, 1, 16'h01D2, 1);
    idle();
    wait_done(2'd0);

    // ADDI 200 out of range
    do_start(8'h20);
    send(5'd21, 4'd1, 4'd0, 16'd200, 0, 16'h0, 0);
    idle();
    chk("err_in_ready", 32'(in_ready), 0);
    wait_done(2'd2);
    chk("err_wc", 32'(word_count), 0);

    // LSHI 16 and MOVI -1 out of range
    do_start(8'h20);
    send(5'd28, 4'd1, 4'd0, 16'd16, 0, 16'h0, 0);
    idle();
    wait_done(2'd2);
    do_start(8'h20);
    send(5'd29, 4'd1, 4'd0, 16'hFFFF, 0, 16'h0, 0);
    idle();
    wait_done(2'd2);

    // illegal mnemonic
    do_start(8'h20);
    send(5'd17, 4'd1, 4'd2, 16'h0, 0, 16'h0, 0);
    idle();
    wait_done(2'd1);

    // top address then overflow
    do_start(8'hFF);
    send(5'd5, 4'd1, 4'd2, 16'h0, 0, 16'h0152, 1);
    send(5'd5, 4'd1, 4'd2, 16'h0, 1, 16'h0, 0);
    idle();
    wait_done(2'd3);
    chk("ovf_wc", 32'(word_count), 1);

    // start while busy is ignored
    do_start(8'h50);
    send(5'd3, 4'd6, 4'd7, 16'h0, 0, 16'h0637, 1);
    @(negedge clk); in_valid = 1'b0; start = 1'b1; base_addr = 8'h90;
    @(negedge clk); start = 1'b0;
    send(5'd1, 4'd2, 4'd3, 16'h0, 1, 16'h0213, 1);
    idle();
    wait_done(2'd0);

    // asynchronous reset mid-stream
    do_start(8'h60);
    send(5'd5, 4'd3, 4'd4, 16'h0, 0, 16'h0354, 1);
    @(negedge clk);
    in_mnemonic = 5'd2; in_rdest = 4'd1; in_rsrc = 4'd1; in_valid = 1'b1;
    #1 reset = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk); in_valid = 1'b0; reset = 1'b0;
    do_start(8'h10);
    send(5'd5, 4'd3, 4'd4, 16'h0, 1, 16'h0354, 1);
    idle();
    wait_done(2'd0);

`ifdef ENCODER_NOP_PAD_EN
    // padding from base 0 up to the next 4-word boundary
    do_start(8'h00);
    send(5'd5, 4'd3, 4'd4, 16'h0, 1, 16'h0354, 1);
    idle();
    wait_done(2'd0);
    chk("pad_wc", 32'(word_count), 4);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
